// File: rtl/div_issue_ctrl.sv
// Requester-side controller for the multi-cycle unsigned divider core.
// Takes RISC-V DIV/DIVU/REM/REMU requests, issues operand magnitudes to the
// core over Start/Done, applies sign fixup and returns a tagged result.
// Divide-by-zero and signed overflow are answered locally without the core.
module div_issue_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [1:0]       ReqOp,
  input  logic [XLEN-1:0]  ReqRs1,
  input  logic [XLEN-1:0]  ReqRs2,
  input  logic [TAG_W-1:0] ReqTag,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [XLEN-1:0]  RspData,
  output logic [TAG_W-1:0] RspTag,
  input  logic             Flush,
  output logic             DivStart,
  output logic [XLEN-1:0]  DivDividend,
  output logic [XLEN-1:0]  DivDivisor,
  input  logic             DivDone,
  input  logic [XLEN-1:0]  DivQuotient,
  input  logic [XLEN-1:0]  DivRemainder
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, DRAIN} state_t;

  state_t     state;
  logic       is_rem_q;
  logic       signed_q;
  logic       s1_q;
  logic       s2_q;
  logic       low_seen_q;

  logic            accept;
  logic            req_signed;
  logic            req_s1;
  logic            req_s2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            overflow;
  logic            bypass;
  logic [XLEN-1:0] bypass_data;
  logic [XLEN-1:0] core_raw;
  logic            core_neg;
  logic [XLEN-1:0] core_fixed;

  assign ReqReady = (state == IDLE);
  // Flush in IDLE blocks acceptance for that cycle.
  assign accept   = ReqValid && ReqReady && !Flush;

  // Request decode: signs, magnitudes and the locally-resolved corner cases.
  always_comb begin
    req_signed  = ~ReqOp[0];
    req_s1      = ReqRs1[XLEN-1];
    req_s2      = ReqRs2[XLEN-1];
    mag1        = (req_signed && req_s1) ? ('0 - ReqRs1) : ReqRs1;
    mag2        = (req_signed && req_s2) ? ('0 - ReqRs2) : ReqRs2;
    div_zero    = (ReqRs2 == '0);
    overflow    = req_signed && (ReqRs1 == INT_MIN) && (ReqRs2 == '1);
    bypass      = div_zero || overflow;
    bypass_data = '0;
    if (div_zero)
      bypass_data = ReqOp[1] ? ReqRs1 : '1;
    else if (overflow)
      bypass_data = ReqOp[1] ? '0 : INT_MIN;
  end

  // Result selection and sign fixup of the core output.
  always_comb begin
    core_raw   = is_rem_q ? DivRemainder : DivQuotient;
    core_neg   = signed_q && (is_rem_q ? s1_q : (s1_q ^ s2_q));
    core_fixed = core_neg ? ('0 - core_raw) : core_raw;
  end

  // Controller FSM with registered response and core-launch outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      is_rem_q    <= 1'b0;
      signed_q    <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      low_seen_q  <= 1'b0;
      RspValid    <= 1'b0;
      RspData     <= '0;
      RspTag      <= '0;
      DivStart    <= 1'b0;
      DivDividend <= '0;
      DivDivisor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_rem_q <= ReqOp[1];
            signed_q <= req_signed;
            s1_q     <= req_s1;
            s2_q     <= req_s2;
            RspTag   <= ReqTag;
            if (bypass) begin
              RspData  <= bypass_data;
              RspValid <= 1'b1;
              state    <= RESP;
            end else begin
              DivDividend <= mag1;
              DivDivisor  <= mag2;
              DivStart    <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Start was already seen by the core this edge, so a flush here
          // must still wait for a full low/high Done cycle.
          DivStart <= 1'b0;
          if (Flush) begin
            low_seen_q <= 1'b0;
            state      <= DRAIN;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (Flush) begin
            // Done has already dropped once the core is past Start.
            low_seen_q <= 1'b1;
            state      <= DRAIN;
          end else if (DivDone) begin
            RspData  <= core_fixed;
            RspValid <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (Flush || RspReady) begin
            RspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (!DivDone)
            low_seen_q <= 1'b1;
          else if (low_seen_q)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
